inst_queue: RTL and testbench

Instruction queue between the instruction-fetch stage and the decoder. It buffers fetched instructions together with their PCs in a circular FIFO and presents them in order to the decoder. It back-pressures fetch through an early stall signal and drops all buffered entries on a control-flow change.

---
 rtl/inst_queue.sv | 99 +++++++++
 tb/tb_inst_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular FIFO of {pc, inst}
// with early stall back-pressure, flush on control-flow change, and a sticky drop flag.
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int SLACK = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             in_valid,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  output logic             stall_out,
  output logic             out_valid,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  input  logic             out_ready,
  output logic [PTR_W:0]   count_out,
  output logic             overflow_out
);

  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] STALL_CNT = (PTR_W+1)'(DEPTH - SLACK);

  logic [63:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;

  logic             w_active;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [63:0]      w_head_entry;

  // A flush or a stalled pipeline (rdy_in low) blocks every transfer.
  assign w_active = rdy_in && !flush_in;
  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_pop    = w_active && !w_empty && out_ready;
  // Pushing into a full queue is legal only when the head leaves in the same cycle.
  assign w_push   = w_active && in_valid && (!w_full || w_pop);
  assign w_drop   = w_active && in_valid && w_full && !w_pop;

  // NOTE: the storage array has no reset; its contents are only observed behind
  // out_valid, so clearing it would add a reset net to every bit for nothing.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_tail] <= {in_pc, in_inst};
    end
  end

  // NOTE: all state uses non-blocking assignments so each register sees the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_tail <= r_tail + 1'b1;
        end
        if (w_pop) begin
          r_head <= r_head + 1'b1;
        end
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  assign w_head_entry = r_mem[r_head];

  assign out_valid    = !w_empty;
  assign out_pc       = out_valid ? w_head_entry[63:32] : '0;
  assign out_inst     = out_valid ? w_head_entry[31:0]  : '0;
  assign stall_out    = (r_count >= STALL_CNT);
  assign count_out    = r_count;
  assign overflow_out = r_overflow;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: a queue-based reference model tracks the
// expected contents; a negedge monitor compares every visible output against it.
module tb_inst_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  localparam int SLACK = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic             rdy_in = 1'b0;
  logic             flush_in = 1'b0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_inst = '0;
  logic [31:0]      in_pc = '0;
  logic             out_ready = 1'b0;
  logic             stall_out;
  logic             out_valid;
  logic [31:0]      out_inst;
  logic [31:0]      out_pc;
  logic [PTR_W:0]   count_out;
  logic             overflow_out;

  entry_t exp_q[$];
  bit     exp_ovf = 1'b0;
  int     n_err = 0;
  int     n_chk = 0;
  int     n_popped = 0;
  int     mon_sz;
  bit     mon_en = 1'b0;

  inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .SLACK(SLACK)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .flush_in     (flush_in),
    .in_valid     (in_valid),
    .in_inst      (in_inst),
    .in_pc        (in_pc),
    .stall_out    (stall_out),
    .out_valid    (out_valid),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_ready    (out_ready),
    .count_out    (count_out),
    .overflow_out (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour for the edge that just happened, from the inputs held across it.
  task automatic model_update();
    bit pop;
    bit push;
    if (!rst_in || !rdy_in) return;
    if (flush_in) begin
      exp_q.delete();
      return;
    end
    pop  = out_ready && (exp_q.size() > 0);
    push = in_valid && ((exp_q.size() < DEPTH) || pop);
    if (pop) begin
      void'(exp_q.pop_front());
      n_popped++;
    end
    if (push) exp_q.push_back({in_pc, in_inst});
    else if (in_valid) exp_ovf = 1'b1;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic ordy,
                      input logic fl, input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = $urandom;
    out_ready = ordy;
    flush_in  = fl;
    rdy_in    = rdy;
    @(posedge clk_in);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush_in  = 1'b0;
    rdy_in    = 1'b1;
    rst_in    = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
  endtask

  always @(negedge clk_in) begin
    if (mon_en) begin
      mon_sz = exp_q.size();
      check("count", count_out, mon_sz);
      check("valid", out_valid, mon_sz != 0);
      check("stall", stall_out, mon_sz >= DEPTH - SLACK);
      check("overflow", overflow_out, exp_ovf);
      if (mon_sz != 0) begin
        check("head_pc", out_pc, exp_q[0].pc);
        check("head_inst", out_inst, exp_q[0].inst);
      end else begin
        check("idle_pc", out_pc, 0);
        check("idle_inst", out_inst, 0);
      end
    end
  end

  initial begin
    int pushed;
    int base;
    int cyc;
    logic v;
    logic [31:0] held_pc;
    logic [31:0] held_inst;

    mon_en = 1'b1;
    do_reset();
    check("reset_count", count_out, 0);
    check("reset_valid", out_valid, 0);

    // Fill with the decoder blocked.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b1);
      if (i == 4) check("fill_stall_at5", stall_out, 0);
      if (i == 5) check("fill_stall_at6", stall_out, 1);
    end
    check("fill_count8", count_out, 8);
    // Full with simultaneous push and pop.
    step(1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
    check("full_simul_count", count_out, 8);
    check("full_simul_ovf", overflow_out, 0);
    check("full_simul_head", out_pc, 32'h04);
    // Ninth push with no pop is dropped.
    step(1'b1, 32'h104, 1'b0, 1'b0, 1'b1);
    check("drop_ovf", overflow_out, 1);
    check("drop_count", count_out, 8);

    // Order and wrap: fetch honours stall, decoder pops every other cycle.
    do_reset();
    pushed = 0;
    base   = n_popped;
    cyc    = 0;
    while ((n_popped - base) < 20 && cyc < 400) begin
      v = (pushed < 20) && !stall_out;
      step(v, 32'(pushed * 4), 1'(cyc % 2), 1'b0, 1'b1);
      if (v) pushed++;
      cyc++;
    end
    check("order_all_popped", n_popped - base, 20);
    check("order_no_ovf", overflow_out, 0);

    // Flush with a simultaneous push.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h80 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
    check("pre_flush_count", count_out, 5);
    step(1'b1, 32'h200, 1'b0, 1'b1, 1'b1);
    check("flush_count", count_out, 0);
    check("flush_valid", out_valid, 0);
    step(1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
    check("post_flush_pc", out_pc, 32'h300);

    // rdy_in low freezes everything.
    step(1'b1, 32'h304, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h308, 1'b0, 1'b0, 1'b1);
    held_pc   = out_pc;
    held_inst = out_inst;
    check("pre_hold_count", count_out, 3);
    repeat (4) step(1'b1, 32'h400, 1'b1, 1'b1, 1'b0);
    check("hold_count", count_out, 3);
    check("hold_pc", out_pc, held_pc);
    check("hold_inst", out_inst, held_inst);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    check("resume_pc", out_pc, 32'h304);

    // Asynchronous reset between edges.
    for (int i = 0; i < 2; i++) step(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0, 1'b1);
    check("pre_reset_count", count_out, 4);
    in_valid = 1'b0;
    #2;
    rst_in = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    check("async_count", count_out, 0);
    check("async_valid", out_valid, 0);
    check("async_stall", stall_out, 0);
    check("async_ovf", overflow_out, 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;

    // Randomized traffic, occasionally ignoring stall to provoke drops.
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0) && (($urandom_range(0, 7) == 0) || !stall_out);
      step(v, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0,
           $urandom_range(0, 9) != 0);
      if (i == 1500) begin
        do_reset();
      end
    end

    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk_in);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
